// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction-register sequencer states, write-select
// codes and the bus/opcode widths the control unit is built against.
package cpu_pkg;

    localparam int DEFAULT_DATA_WIDTH   = 8;
    localparam int DEFAULT_OPCODE_WIDTH = 4;
    localparam int WRITE_SEL_SHORT      = 0;

    typedef enum logic [1:0] {
        S_EMPTY   = 2'd0,
        S_DECODE  = 2'd1,
        S_OPERAND = 2'd2,
        S_READY   = 2'd3
    } ir_state_e;

endpackage

// File: rtl/ir_bus_driver.sv
// Write path of the instruction register: selects the short immediate or one
// operand byte and drives it onto the shared bus, otherwise releases the bus.
module ir_bus_driver
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int OPCODE_WIDTH = DEFAULT_OPCODE_WIDTH,
    parameter int MAX_OPERANDS = 2,
    parameter int LEN_WIDTH    = 2
) (
    input  logic [DATA_WIDTH-OPCODE_WIDTH-1:0]          i_SHORT,
    input  logic [MAX_OPERANDS-1:0][DATA_WIDTH-1:0]     i_OPERANDS,
    input  logic                                        i_WRITE_BUS,
    input  logic [LEN_WIDTH-1:0]                        i_WRITE_SEL,
    inout  wire  [DATA_WIDTH-1:0]                       BUS
);

    logic [DATA_WIDTH-1:0] drive_val_s;

    // Field select; any code past the last operand reads as zero
    always_comb begin
        drive_val_s = {DATA_WIDTH{1'b0}};
        if (i_WRITE_SEL == LEN_WIDTH'(WRITE_SEL_SHORT)) begin
            drive_val_s = {{OPCODE_WIDTH{1'b0}}, i_SHORT};
        end else begin
            for (int k = 0; k < MAX_OPERANDS; k++) begin
                if (i_WRITE_SEL == LEN_WIDTH'(k + 1)) begin
                    drive_val_s = i_OPERANDS[k];
                end else begin
                    drive_val_s = drive_val_s;
                end
            end
        end
    end

    assign BUS = i_WRITE_BUS ? drive_val_s : {DATA_WIDTH{1'bz}};

endmodule

// File: rtl/multi_byte_instruction_register.sv
// Multi-byte instruction register: captures an opcode byte and up to
// MAX_OPERANDS operand bytes, with a one-cycle length handshake to the CU.
module multi_byte_instruction_register
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int OPCODE_WIDTH = DEFAULT_OPCODE_WIDTH,
    parameter int MAX_OPERANDS = 2,
    parameter int LEN_WIDTH    = 2
) (
    input  logic                    i_CLOCK,
    input  logic                    i_CLEAR,
    inout  wire  [DATA_WIDTH-1:0]   BUS,
    input  logic                    i_READ_BUS,
    input  logic                    i_WRITE_BUS,
    input  logic [LEN_WIDTH-1:0]    i_WRITE_SEL,
    input  logic                    i_FLUSH,
    input  logic [LEN_WIDTH-1:0]    i_LEN,
    output logic [OPCODE_WIDTH-1:0] o_OPCODE,
    output logic                    o_DECODE,
    output logic                    o_READY,
    output logic [LEN_WIDTH-1:0]    o_OPERAND_INDEX,
    output logic                    o_LEN_ERROR
);

    localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(MAX_OPERANDS);

    ir_state_e                           state_r, state_nxt_s;
    logic [DATA_WIDTH-1:0]               byte0_r;
    logic [MAX_OPERANDS-1:0][DATA_WIDTH-1:0] operands_r;
    logic [LEN_WIDTH-1:0]                count_r, count_nxt_s;
    logic [LEN_WIDTH-1:0]                index_r, index_nxt_s;
    logic                                len_error_r;
    logic                                load_byte0_s, clear_ops_s, load_op_s, set_err_s;
    logic                                len_over_s;
    logic [LEN_WIDTH-1:0]                len_clamped_s;

    assign len_over_s    = (i_LEN > MAX_LEN);
    assign len_clamped_s = len_over_s ? MAX_LEN : i_LEN;

    // Sequencer next-state; flush outranks any bus capture
    always_comb begin
        state_nxt_s  = state_r;
        count_nxt_s  = count_r;
        index_nxt_s  = index_r;
        load_byte0_s = 1'b0;
        clear_ops_s  = 1'b0;
        load_op_s    = 1'b0;
        set_err_s    = 1'b0;
        if (i_FLUSH) begin
            state_nxt_s = S_EMPTY;
            index_nxt_s = {LEN_WIDTH{1'b0}};
        end else begin
            case (state_r)
                S_EMPTY, S_READY: begin
                    if (i_READ_BUS) begin
                        load_byte0_s = 1'b1;
                        clear_ops_s  = 1'b1;
                        state_nxt_s  = S_DECODE;
                    end else begin
                        state_nxt_s  = state_r;
                    end
                end
                S_DECODE: begin
                    count_nxt_s = len_clamped_s;
                    set_err_s   = len_over_s;
                    index_nxt_s = {LEN_WIDTH{1'b0}};
                    if (len_clamped_s == {LEN_WIDTH{1'b0}}) begin
                        state_nxt_s = S_READY;
                    end else begin
                        state_nxt_s = S_OPERAND;
                    end
                end
                S_OPERAND: begin
                    if (i_READ_BUS) begin
                        load_op_s   = 1'b1;
                        index_nxt_s = index_r + LEN_WIDTH'(1);
                        if (index_r == count_r - LEN_WIDTH'(1)) begin
                            state_nxt_s = S_READY;
                        end else begin
                            state_nxt_s = S_OPERAND;
                        end
                    end else begin
                        state_nxt_s = S_OPERAND;
                    end
                end
                default: begin
                    state_nxt_s = S_EMPTY;
                end
            endcase
        end
    end

    // State, counters and captured bytes
    always_ff @(posedge i_CLOCK) begin
        if (i_CLEAR) begin
            state_r     <= S_EMPTY;
            byte0_r     <= {DATA_WIDTH{1'b0}};
            operands_r  <= '0;
            count_r     <= {LEN_WIDTH{1'b0}};
            index_r     <= {LEN_WIDTH{1'b0}};
            len_error_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            count_r <= count_nxt_s;
            index_r <= index_nxt_s;
            if (load_byte0_s) begin
                byte0_r <= BUS;
            end
            if (set_err_s) begin
                len_error_r <= 1'b1;
            end
            for (int k = 0; k < MAX_OPERANDS; k++) begin
                if (clear_ops_s) begin
                    operands_r[k] <= {DATA_WIDTH{1'b0}};
                end else if (load_op_s && (index_r == LEN_WIDTH'(k))) begin
                    operands_r[k] <= BUS;
                end
            end
        end
    end

    assign o_OPCODE        = byte0_r[DATA_WIDTH-1 -: OPCODE_WIDTH];
    assign o_DECODE        = (state_r == S_DECODE);
    assign o_READY         = (state_r == S_READY);
    assign o_OPERAND_INDEX = index_r;
    assign o_LEN_ERROR     = len_error_r;

    ir_bus_driver #(
        .DATA_WIDTH   (DATA_WIDTH),
        .OPCODE_WIDTH (OPCODE_WIDTH),
        .MAX_OPERANDS (MAX_OPERANDS),
        .LEN_WIDTH    (LEN_WIDTH)
    ) u_bus_driver (
        .i_SHORT     (byte0_r[DATA_WIDTH-OPCODE_WIDTH-1:0]),
        .i_OPERANDS  (operands_r),
        .i_WRITE_BUS (i_WRITE_BUS),
        .i_WRITE_SEL (i_WRITE_SEL),
        .BUS         (BUS)
    );

endmodule

// File: tb/tb_multi_byte_instruction_register.sv
// Directed bench for the multi-byte instruction register (DATA 8, OPCODE 4,
// MAX_OPERANDS 2); expected values are worked out by hand from the fetch rules.
module tb_multi_byte_instruction_register;

    logic       i_CLOCK = 1'b0;
    logic       i_CLEAR, i_READ_BUS, i_WRITE_BUS, i_FLUSH;
    logic [1:0] i_WRITE_SEL, i_LEN;
    logic [3:0] o_OPCODE;
    logic       o_DECODE, o_READY, o_LEN_ERROR;
    logic [1:0] o_OPERAND_INDEX;
    wire  [7:0] bus;
    logic [7:0] tb_bus_val;
    logic       tb_bus_en;
    int         n_vec = 0;
    int         n_miss = 0;

    assign bus = tb_bus_en ? tb_bus_val : 8'bz;

    multi_byte_instruction_register #(
        .DATA_WIDTH(8), .OPCODE_WIDTH(4), .MAX_OPERANDS(2), .LEN_WIDTH(2)
    ) dut (
        .i_CLOCK(i_CLOCK), .i_CLEAR(i_CLEAR), .BUS(bus),
        .i_READ_BUS(i_READ_BUS), .i_WRITE_BUS(i_WRITE_BUS),
        .i_WRITE_SEL(i_WRITE_SEL), .i_FLUSH(i_FLUSH), .i_LEN(i_LEN),
        .o_OPCODE(o_OPCODE), .o_DECODE(o_DECODE), .o_READY(o_READY),
        .o_OPERAND_INDEX(o_OPERAND_INDEX), .o_LEN_ERROR(o_LEN_ERROR)
    );

    always #5 i_CLOCK = ~i_CLOCK;

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_CLOCK);
        #1;
    endtask

    // Capture one byte from the bench-driven bus
    task automatic read_byte(input logic [7:0] val);
        tb_bus_val = val;
        tb_bus_en  = 1'b1;
        i_READ_BUS = 1'b1;
        tick();
        i_READ_BUS = 1'b0;
        tb_bus_en  = 1'b0;
    endtask

    // Spend the decode cycle presenting a length
    task automatic decode_len(input logic [1:0] len);
        i_LEN = len;
        tick();
    endtask

    task automatic check_write(input string tag, input logic [1:0] sel, input logic [7:0] exp);
        i_WRITE_SEL = sel;
        i_WRITE_BUS = 1'b1;
        #1;
        check_vec(tag, {24'd0, bus}, {24'd0, exp});
        i_WRITE_BUS = 1'b0;
        #1;
    endtask

    task automatic check_status(input string tag, input logic [3:0] opc, input logic dec,
                                input logic rdy, input logic [1:0] idx, input logic err);
        check_vec({tag, ".opcode"}, {28'd0, o_OPCODE}, {28'd0, opc});
        check_vec({tag, ".decode"}, {31'd0, o_DECODE}, {31'd0, dec});
        check_vec({tag, ".ready"},  {31'd0, o_READY},  {31'd0, rdy});
        check_vec({tag, ".index"},  {30'd0, o_OPERAND_INDEX}, {30'd0, idx});
        check_vec({tag, ".lenerr"}, {31'd0, o_LEN_ERROR}, {31'd0, err});
    endtask

    initial begin
        i_CLEAR = 1'b1; i_READ_BUS = 1'b0; i_WRITE_BUS = 1'b0; i_FLUSH = 1'b0;
        i_WRITE_SEL = 2'd0; i_LEN = 2'd0; tb_bus_val = 8'h00; tb_bus_en = 1'b0;
        tick();
        tick();
        check_status("reset", 4'h0, 1'b0, 1'b0, 2'd0, 1'b0);
        i_CLEAR = 1'b0;

        // Zero-operand instruction
        read_byte(8'h3A);
        check_status("t1_dec", 4'h3, 1'b1, 1'b0, 2'd0, 1'b0);
        decode_len(2'd0);
        check_status("t1_rdy", 4'h3, 1'b0, 1'b1, 2'd0, 1'b0);
        check_write("t1_short", 2'd0, 8'h0A);

        // Two operands
        read_byte(8'h52);
        decode_len(2'd2);
        check_status("t2_op0", 4'h5, 1'b0, 1'b0, 2'd0, 1'b0);
        read_byte(8'hC4);
        check_status("t2_op1", 4'h5, 1'b0, 1'b0, 2'd1, 1'b0);
        read_byte(8'h7F);
        check_status("t2_rdy", 4'h5, 1'b0, 1'b1, 2'd2, 1'b0);
        check_write("t2_sel1", 2'd1, 8'hC4);
        check_write("t2_sel2", 2'd2, 8'h7F);
        check_write("t2_sel3", 2'd3, 8'h00);
        check_write("t2_short", 2'd0, 8'h02);

        // Over-length request clamps to MAX and sets the sticky error
        read_byte(8'h10);
        decode_len(2'd3);
        check_status("t3_op0", 4'h1, 1'b0, 1'b0, 2'd0, 1'b1);
        read_byte(8'hAA);
        read_byte(8'hBB);
        check_status("t3_rdy", 4'h1, 1'b0, 1'b1, 2'd2, 1'b1);
        check_write("t3_sel2", 2'd2, 8'hBB);

        // Back-to-back fetch from S_READY clears operands
        read_byte(8'h20);
        check_status("t4_dec", 4'h2, 1'b1, 1'b0, 2'd2, 1'b1);
        check_write("t4_clr1", 2'd1, 8'h00);
        check_write("t4_clr2", 2'd2, 8'h00);
        decode_len(2'd1);
        read_byte(8'h99);
        check_status("t4_rdy", 4'h2, 1'b0, 1'b1, 2'd1, 1'b1);
        check_write("t4_sel1", 2'd1, 8'h99);

        // Flush beats a simultaneous read
        read_byte(8'h30);
        decode_len(2'd2);
        read_byte(8'h11);
        i_FLUSH = 1'b1;
        read_byte(8'h22);
        i_FLUSH = 1'b0;
        check_status("t5_flush", 4'h3, 1'b0, 1'b0, 2'd0, 1'b1);
        check_write("t5_keep1", 2'd1, 8'h11);
        check_write("t5_nocap", 2'd2, 8'h00);
        tick();
        check_vec("t5_idle", {31'd0, o_DECODE}, 32'd0);

        // Clear in the middle of an operand fetch
        read_byte(8'h40);
        decode_len(2'd1);
        check_vec("t5_inop", {30'd0, o_OPERAND_INDEX}, 32'd0);
        i_CLEAR = 1'b1;
        tick();
        i_CLEAR = 1'b0;
        check_status("t5_clear", 4'h0, 1'b0, 1'b0, 2'd0, 1'b0);
        check_write("t5_clrop", 2'd0, 8'h00);

        // Bus released while not writing: bench-driven values pass untouched
        tb_bus_val = 8'h5A; tb_bus_en = 1'b1; #1;
        check_vec("t6_rel_5a", {24'd0, bus}, 32'h5A);
        tb_bus_val = 8'hA5; #1;
        check_vec("t6_rel_a5", {24'd0, bus}, 32'hA5);
        tb_bus_en = 1'b0;

        // Simultaneous read and write of the short field
        read_byte(8'hB7);
        decode_len(2'd0);
        check_status("t6_rdy", 4'hB, 1'b0, 1'b1, 2'd0, 1'b0);
        i_WRITE_SEL = 2'd0;
        i_WRITE_BUS = 1'b1;
        i_READ_BUS  = 1'b1;
        tick();
        i_READ_BUS  = 1'b0;
        i_WRITE_BUS = 1'b0;
        check_status("t6_self", 4'h0, 1'b1, 1'b0, 2'd0, 1'b0);
        check_write("t6_short", 2'd0, 8'h07);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
